// File: rtl/param_stop_counter.sv
// Up/down counter over 0..MAX_COUNT with stop-or-recycle at the terminal value,
// sticky threshold flag and wrap pulse. Define PSC_DIV_EN to add the step prescaler.
module param_stop_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7,
    parameter int THRESH    = 3,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             recycle,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             thresh_hit,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] THR_C = WIDTH'(THRESH);

    if (MAX_COUNT >= (2 ** WIDTH) || THRESH > MAX_COUNT || PRESCALE < 1) begin : g_bad_params
        $error("param_stop_counter: illegal parameter combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term;
    logic             thresh_q, thresh_d;
    logic             wrap_q, wrap_d;
    logic             step;

`ifdef PSC_DIV_EN
    localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    // Only the PRESCALE-th enabled cycle becomes a real count step.
    always_comb begin
        psc_d = psc_q;
        step  = 1'b0;
        if (clr || load) begin
            psc_d = '0;
        end else if (en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                step  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    always_comb begin
        step = en;
    end
`endif

    always_comb begin
        term     = dir ? MAX_C : '0;
        count_d  = count_q;
        thresh_d = thresh_q;
        wrap_d   = 1'b0;
        if (clr) begin
            count_d  = '0;
            thresh_d = 1'b0;
        end else begin
            if (load) begin
                count_d = (load_val > MAX_C) ? MAX_C : load_val;
            end else if (step) begin
                if (count_q != term) begin
                    count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
                end else if (recycle) begin
                    count_d = dir ? '0 : MAX_C;
                    wrap_d  = 1'b1;
                end
            end
            if (count_d == THR_C) begin
                thresh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            thresh_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            thresh_q <= thresh_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count      = count_q;
    assign thresh_hit = thresh_q;
    assign wrap       = wrap_q;
    assign done       = !recycle && (count_q == term);

endmodule

// File: tb/tb_param_stop_counter.sv
// Scoreboard bench: two instances (MAX_COUNT 7 and 5) driven identically and
// compared every cycle against a behavioural model of the counter rules.
module tb_param_stop_counter;

    localparam int TH = 3;
    localparam int PS = 4;

    typedef struct {
        int cnt;
        bit thr;
        bit wrp;
        bit dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, recycle = 1'b0;
    logic [2:0] load_val = '0;

    logic [2:0] count0, count1;
    logic       done0, done1, thr0, thr1, wrap0, wrap1;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_cnt[2];
    bit m_thr[2];
    bit m_wrp[2];
    int m_psc[2];
    int maxv[2] = '{7, 5};

    always #5 clk = ~clk;

    param_stop_counter #(.WIDTH(3), .MAX_COUNT(7), .THRESH(TH), .PRESCALE(PS)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .recycle(recycle), .count(count0), .done(done0),
        .thresh_hit(thr0), .wrap(wrap0)
    );

    param_stop_counter #(.WIDTH(3), .MAX_COUNT(5), .THRESH(TH), .PRESCALE(PS)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .recycle(recycle), .count(count1), .done(done1),
        .thresh_hit(thr1), .wrap(wrap1)
    );

    task automatic check(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, inst, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs and predict the post-edge state of both instances.
    task automatic drive(input bit r, input bit e, input bit c, input bit l,
                         input int lv, input bit d, input bit rc);
        exp_t x;
        bit   fire;
        @(negedge clk);
        rst = r; en = e; clr = c; load = l; load_val = 3'(lv); dir = d; recycle = rc;
        for (int i = 0; i < 2; i++) begin
            m_wrp[i] = 1'b0;
            if (!r || c) begin
                m_cnt[i] = 0;
                m_thr[i] = 1'b0;
                m_psc[i] = 0;
            end else begin
                if (l) begin
                    m_cnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
                    m_psc[i] = 0;
                end else if (e) begin
`ifdef PSC_DIV_EN
                    m_psc[i] = (m_psc[i] + 1) % PS;
                    fire = (m_psc[i] == 0);
`else
                    fire = 1'b1;
`endif
                    if (fire) begin
                        if (d) begin
                            if (m_cnt[i] < maxv[i]) m_cnt[i]++;
                            else if (rc) begin m_cnt[i] = 0; m_wrp[i] = 1'b1; end
                        end else begin
                            if (m_cnt[i] > 0) m_cnt[i]--;
                            else if (rc) begin m_cnt[i] = maxv[i]; m_wrp[i] = 1'b1; end
                        end
                    end
                end
                if (m_cnt[i] == TH) m_thr[i] = 1'b1;
            end
            x.cnt = m_cnt[i];
            x.thr = m_thr[i];
            x.wrp = m_wrp[i];
            x.dn  = !rc && (m_cnt[i] == (d ? maxv[i] : 0));
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    // Monitor: registered outputs are settled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q0.size() > 0) begin
            x = q0.pop_front();
            check("count", 0, int'(count0), x.cnt);
            check("thresh_hit", 0, int'(thr0), int'(x.thr));
            check("wrap", 0, int'(wrap0), int'(x.wrp));
            check("done", 0, int'(done0), int'(x.dn));
        end
        if (q1.size() > 0) begin
            x = q1.pop_front();
            check("count", 1, int'(count1), x.cnt);
            check("thresh_hit", 1, int'(thr1), int'(x.thr));
            check("wrap", 1, int'(wrap1), int'(x.wrp));
            check("done", 1, int'(done1), int'(x.dn));
        end
    end

    initial begin
        int waited;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_thr[i] = 1'b0; m_wrp[i] = 1'b0; m_psc[i] = 0;
        end
        // Reset, then flip direction so done decodes the zero terminal.
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        // Count up in stop mode past the terminal.
        for (int k = 0; k < 10; k++) drive(1, 1, 0, 0, 0, 1, 0);
        // Recycle up from zero through the wrap.
        drive(1, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 9; k++) drive(1, 1, 0, 0, 0, 1, 1);
        // Load 5 then count down into the zero stop.
        drive(1, 0, 1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 5, 1, 0);
        for (int k = 0; k < 7; k++) drive(1, 1, 0, 0, 0, 0, 0);
        // Clamp on out-of-range load, then clear beats load.
        drive(1, 0, 0, 1, 6, 1, 0);
        drive(1, 0, 0, 1, 7, 1, 0);
        drive(1, 0, 1, 1, 3, 1, 0);
        // Reset in the middle of counting.
        drive(1, 0, 0, 1, 4, 1, 0);
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 2, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        // Eight enabled cycles from a clean start, then en gaps in between.
        drive(1, 0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) drive(1, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) drive(1, k % 3 != 0, 0, 0, 0, 1, 1);
        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(39, 0) != 0, $urandom_range(3, 0) != 0,
                  $urandom_range(19, 0) == 0, $urandom_range(7, 0) == 0,
                  int'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1);
        end
        waited = 0;
        while ((q0.size() > 0 || q1.size() > 0) && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("drain", 0, q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
